// File: rtl/frame_sched_pkg.sv
// Shared definitions for the double-buffered occupancy frame buffer scheduler:
// FSM state encoding and RAM index helpers.
package frame_sched_pkg;

    typedef enum logic [1:0] {
        INIT_CLR   = 2'd0,
        CLEAR      = 2'd1,
        DRAW       = 2'd2,
        WAIT_VSYNC = 2'd3
    } fb_state_t;

    localparam int RAM0 = 0;
    localparam int RAM1 = 1;

    // One-hot per-RAM strobe for the RAM selected by sel (0 -> RAM0, 1 -> RAM1).
    function automatic logic [1:0] ram_bit(input logic sel);
        return sel ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/fb_clear_sweeper.sv
// Address sweep counter for buffer clears: walks 0..DEPTH-1 while enabled,
// flags the final address, and wraps back to 0 ready for the next sweep.
module fb_clear_sweeper #(
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  en,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  done
);

    // One extra bit so DEPTH == 2**ADDR_WIDTH compares without wrap ambiguity.
    localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH+1)'(DEPTH - 1);

    logic [ADDR_WIDTH:0] cnt;

    assign addr = cnt[ADDR_WIDTH-1:0];
    assign done = en && (cnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (start || done) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/frame_buffer_scheduler.sv
// Sequences the two 1-bit occupancy RAMs: initial/back-buffer clears, boid pixel
// writes into the back buffer, and front/back swap on vsync once a frame is complete.
module frame_buffer_scheduler
    import frame_sched_pkg::*;
#(
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = 10,
    parameter int DROP_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  vsync,
    input  logic                  draw_valid,
    input  logic [ADDR_WIDTH-1:0] draw_addr,
    input  logic                  draw_last,
    output logic                  draw_ready,
    output logic [1:0]            ram_we,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [1:0]            ram_wdata,
    output logic                  front_sel,
    output logic                  frame_ready,
    output logic                  oob_err,
    output logic [DROP_WIDTH-1:0] drop_count
);

    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

    function automatic logic [DROP_WIDTH-1:0] sat_inc(input logic [DROP_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    fb_state_t             state, state_nx;
    logic                  vsync_q, vsync_rise;
    logic                  accept, in_range;
    logic                  sweep_en, sweep_start, sweep_done;
    logic [ADDR_WIDTH-1:0] sweep_addr;
    logic [1:0]            we_nx, wdata_nx;
    logic [ADDR_WIDTH-1:0] waddr_nx;

    assign vsync_rise = vsync && !vsync_q;
    assign accept     = draw_valid && draw_ready;
    assign in_range   = {1'b0, draw_addr} < DEPTH_W;

    fb_clear_sweeper #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_sweeper (
        .clk   (clk),
        .reset (reset),
        .start (sweep_start),
        .en    (sweep_en),
        .addr  (sweep_addr),
        .done  (sweep_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= INIT_CLR;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            INIT_CLR, CLEAR: if (sweep_done) state_nx = DRAW;
            DRAW:            if (accept && draw_last) state_nx = WAIT_VSYNC;
            WAIT_VSYNC:      if (vsync_rise) state_nx = CLEAR;
            default:         state_nx = INIT_CLR;
        endcase
    end

    // Write-port request for the next cycle; only INIT_CLR may touch the front RAM.
    always_comb begin
        draw_ready  = (state == DRAW);
        frame_ready = (state == WAIT_VSYNC);
        sweep_en    = (state == INIT_CLR) || (state == CLEAR);
        sweep_start = (state == WAIT_VSYNC) && vsync_rise;
        we_nx       = 2'b00;
        wdata_nx    = 2'b00;
        waddr_nx    = '0;
        case (state)
            INIT_CLR: begin
                we_nx    = 2'b11;
                waddr_nx = sweep_addr;
            end
            CLEAR: begin
                we_nx    = ram_bit(~front_sel);
                waddr_nx = sweep_addr;
            end
            DRAW: begin
                if (accept && in_range) begin
                    we_nx    = ram_bit(~front_sel);
                    wdata_nx = ram_bit(~front_sel);
                    waddr_nx = draw_addr;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vsync_q    <= 1'b0;
            ram_we     <= 2'b00;
            ram_wdata  <= 2'b00;
            ram_waddr  <= '0;
            front_sel  <= 1'b0;
            oob_err    <= 1'b0;
            drop_count <= '0;
        end else begin
            vsync_q   <= vsync;
            ram_we    <= we_nx;
            ram_wdata <= wdata_nx;
            ram_waddr <= waddr_nx;
            if (state == WAIT_VSYNC && vsync_rise) begin
                front_sel <= ~front_sel;
            end
            if (accept && !in_range) begin
                oob_err <= 1'b1;
            end
            // A vsync anywhere but WAIT_VSYNC means the frame missed its slot.
            if (vsync_rise && state != WAIT_VSYNC) begin
                drop_count <= sat_inc(drop_count);
            end
        end
    end

endmodule
